ddrc_apb_user_master: RTL
=========================

Name: ddrc_apb_user_master

Overview:
- Upstream neighbour of the DDRC reset/init controller.
- Converts a valid/ready register-command stream from user logic into APB3 transfers on the controller's user_p* inputs.
- Holds off all traffic until ddr_init_done is high.
- Adds per-transfer pready timeout, a user-requested APB soft reset (user_preset pulse) and a saturating timeout error counter.

Parameters:
- TIMEOUT_CYCLES, 256: cycles in ACCESS without pready before abort; 0 disables the timeout.
- PRESET_CYCLES, 16: width in pclk cycles of a soft-reset pulse on apb_preset; legal range 1..255.
- ADDR_W, 12: APB address width.
- DATA_W, 32: APB data width.

Ports:
- pclk  in  1  APB clock.
- resetn  in  1  synchronous active-low reset, sampled on pclk rising edge.
- ddr_init_done  in  1  from the reset/init controller; gates command acceptance.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  register address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_timeout  out  1  transfer aborted by timeout.
- soft_rst_req  in  1  single-cycle request for an APB soft reset.
- apb_preset  out  1  active-high, to user_preset.
- apb_psel  out  1  to user_psel.
- apb_penable  out  1  to user_penable.
- apb_pwrite  out  1  to user_pwrite.
- apb_paddr  out  ADDR_W  to user_paddr.
- apb_pwdata  out  DATA_W  to user_pwdata.
- apb_prdata  in  DATA_W  from ddrc_prdata.
- apb_pready  in  1  from ddrc_pready.
- timeout_cnt  out  8  saturating count of timed-out transfers.

Behaviour:
- Reset (resetn low at an edge): state IDLE. All outputs 0, including cmd_ready, rsp_*, apb_*, timeout_cnt. Soft-reset pending flag cleared. An in-flight transfer is dropped without a response.
- States: IDLE, SETUP, ACCESS, RESP, PRESET.
- IDLE:
  - cmd_ready = ddr_init_done && !rst_pending, registered.
  - On accept, latch write/addr/wdata into apb_pwrite/apb_paddr/apb_pwdata; next state SETUP.
- SETUP: apb_psel=1, apb_penable=0 for exactly 1 cycle; next state ACCESS.
- ACCESS:
  - apb_psel=1, apb_penable=1.
  - Timeout counter clears on SETUP entry and increments each ACCESS cycle.
  - If apb_pready=1: capture apb_prdata (reads only; 0 for writes), rsp_timeout=0, go to RESP.
  - Else if the counter reaches TIMEOUT_CYCLES-1 (and TIMEOUT_CYCLES != 0): rsp_rdata=0, rsp_timeout=1, timeout_cnt += 1 (saturates at 255), go to RESP.
  - pready has priority over timeout when both occur in the same cycle.
- RESP:
  - apb_psel=apb_penable=0; rsp_valid=1, holding data until rsp_ready=1.
  - Then go to PRESET if rst_pending, else IDLE.
  - rsp_valid and rsp_ready may be high in the same cycle RESP is entered; response completes that cycle.
- Latency: accept at cycle N, SETUP at N+1, ACCESS at N+2. With pready at N+2, rsp_valid rises at N+3. Minimum command-to-command spacing is 4 cycles.
- APB stability: apb_paddr, apb_pwrite, apb_pwdata remain stable from SETUP through the last ACCESS cycle and hold their last values in IDLE.
- Soft reset:
  - soft_rst_req sets rst_pending in any state.
  - Serviced from IDLE, with priority over a same-cycle cmd_valid, or on RESP exit; it never interrupts a transfer.
  - In PRESET: apb_preset=1 for exactly PRESET_CYCLES cycles, then cleared; rst_pending cleared on entry; return to IDLE; cmd_ready stays 0 throughout PRESET.
  - A soft_rst_req arriving during PRESET sets rst_pending again, giving one further pulse afterwards.
- ddr_init_done falling mid-transfer: the current transfer and its response complete; no new accept until it rises again.

Decomposition:
- Package ddrc_apb_pkg holds the state enum (IDLE/SETUP/ACCESS/RESP/PRESET), APB width constants, and the counter-width function (clog2).
- No sub-module required; the timeout counter and preset counter are inline counters.

Test Plan:
- ddr_init_done=0, cmd_valid=1 for 50 cycles -> cmd_ready=0, apb_psel never 1. Raise init_done -> accept within 1 cycle.
- Write addr 0x004, wdata 0xDEADBEEF, pready tied 1 -> psel at N+1, penable at N+2, rsp_valid at N+3, rsp_timeout=0, rsp_rdata=0.
- Read addr 0x010, pready after 5 ACCESS cycles with prdata 0x12345678 -> rsp_rdata=0x12345678. Paddr stable for all 6 psel cycles.
- TIMEOUT_CYCLES=8, pready tied 0 -> abort after 8 ACCESS cycles, rsp_timeout=1, timeout_cnt=1. Repeat 300 times -> timeout_cnt=255.
- soft_rst_req during ACCESS -> transfer completes and rsp is consumed, then apb_preset=1 for exactly 16 cycles with cmd_ready=0, then IDLE.
- resetn low for 1 cycle mid-ACCESS -> next cycle all outputs 0, state IDLE, no rsp_valid issued.

Source files
------------

// File: rtl/ddrc_apb_user_master_pkg.sv
// Shared types and constants for the DDRC APB user-side master.
package ddrc_apb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_RESP   = 3'd3,
      ST_PRESET = 3'd4
   } state_t;

   localparam int unsigned APB_ADDR_W = 12;
   localparam int unsigned APB_DATA_W = 32;

   // Number of bits needed to hold values 0..max_val (at least 1).
   function automatic int unsigned cnt_w(input int unsigned max_val);
      int unsigned w;
      w = 1;
      while ((w < 32) && ((64'(1) << w) <= 64'(max_val)))
         w++;
      return w;
   endfunction

endpackage

// File: rtl/ddrc_apb_user_master.sv
// Bridges a valid/ready register-command stream onto the DDRC user APB3
// port, with a pready timeout, a user soft-reset pulse and a saturating
// timeout error counter. Traffic is held off until ddr_init_done.
module ddrc_apb_user_master
   import ddrc_apb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned PRESET_CYCLES  = 16,
   parameter int unsigned ADDR_W         = APB_ADDR_W,
   parameter int unsigned DATA_W         = APB_DATA_W
) (
   input  logic              pclk,
   input  logic              resetn,
   input  logic              ddr_init_done,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_timeout,
   input  logic              soft_rst_req,
   output logic              apb_preset,
   output logic              apb_psel,
   output logic              apb_penable,
   output logic              apb_pwrite,
   output logic [ADDR_W-1:0] apb_paddr,
   output logic [DATA_W-1:0] apb_pwdata,
   input  logic [DATA_W-1:0] apb_prdata,
   input  logic              apb_pready,
   output logic [7:0]        timeout_cnt
);

   localparam int unsigned   TW     = cnt_w(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]    P_LAST = 8'(PRESET_CYCLES - 1);
   localparam bit            T_EN   = (TIMEOUT_CYCLES != 0);

   state_t        state;
   logic          rst_pending;
   logic          pend_nxt;
   logic [TW-1:0] tcnt;
   logic [7:0]    pcnt;

   // A request arriving this cycle counts as pending for this cycle's decisions.
   always_comb begin
      pend_nxt = rst_pending | soft_rst_req;
   end

   // APB strobes and response/reset flags decode directly from the state register.
   assign apb_psel    = (state == ST_SETUP) || (state == ST_ACCESS);
   assign apb_penable = (state == ST_ACCESS);
   assign rsp_valid   = (state == ST_RESP);
   assign apb_preset  = (state == ST_PRESET);

   // Main transfer FSM with inline timeout and preset counters.
   always_ff @(posedge pclk) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         rst_pending <= 1'b0;
         cmd_ready   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_timeout <= 1'b0;
         apb_pwrite  <= 1'b0;
         apb_paddr   <= '0;
         apb_pwdata  <= '0;
         timeout_cnt <= '0;
         tcnt        <= '0;
         pcnt        <= '0;
      end else begin
         rst_pending <= pend_nxt;
         case (state)
            ST_IDLE: begin
               if (pend_nxt) begin
                  // Soft reset wins over a command offered in the same cycle.
                  state       <= ST_PRESET;
                  rst_pending <= 1'b0;
                  pcnt        <= '0;
                  cmd_ready   <= 1'b0;
               end else if (cmd_valid && cmd_ready) begin
                  state      <= ST_SETUP;
                  cmd_ready  <= 1'b0;
                  apb_pwrite <= cmd_write;
                  apb_paddr  <= cmd_addr;
                  apb_pwdata <= cmd_wdata;
                  tcnt       <= '0;
               end else begin
                  cmd_ready <= ddr_init_done;
               end
            end
            ST_SETUP: begin
               state <= ST_ACCESS;
            end
            ST_ACCESS: begin
               tcnt <= tcnt + 1'b1;
               if (apb_pready) begin
                  rsp_rdata   <= apb_pwrite ? '0 : apb_prdata;
                  rsp_timeout <= 1'b0;
                  state       <= ST_RESP;
               end else if (T_EN && (tcnt == T_LAST)) begin
                  rsp_rdata   <= '0;
                  rsp_timeout <= 1'b1;
                  if (timeout_cnt != 8'hFF)
                     timeout_cnt <= timeout_cnt + 8'd1;
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  if (pend_nxt) begin
                     state       <= ST_PRESET;
                     rst_pending <= 1'b0;
                     pcnt        <= '0;
                  end else begin
                     state     <= ST_IDLE;
                     cmd_ready <= ddr_init_done;
                  end
               end
            end
            ST_PRESET: begin
               pcnt <= pcnt + 8'd1;
               if (pcnt == P_LAST) begin
                  state     <= ST_IDLE;
                  cmd_ready <= ddr_init_done && !pend_nxt;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
